// File: rtl/entropy_pkg.sv
// rtl/entropy_pkg.sv - shared types and constants for the entropy pool scheduler
package entropy_pkg;

   localparam int POOL_BITS_DEFAULT = 512;
   localparam int NUM_REQ           = 2;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_READY = 2'd1,
      ST_SERVE = 2'd2
   } state_t;

   // Never declare a pool full before every bit has been written at least once.
   function automatic logic [31:0] fill_threshold(input logic [31:0] n_samples,
                                                  input logic [31:0] pool_bits);
      return (n_samples > pool_bits) ? n_samples : pool_bits;
   endfunction

endpackage

// File: rtl/entropy_xor_pool.sv
// rtl/entropy_xor_pool.sv - sample edge detection and XOR-parity pool accumulation
module entropy_xor_pool
   import entropy_pkg::*;
#(
   parameter int POOL_BITS = POOL_BITS_DEFAULT
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [31:0]          entropy,
   input  logic                 entropy_ready,
   input  logic                 clear,
   output logic [POOL_BITS-1:0] pool,
   output logic [31:0]          sample_count
);

   localparam int IDX_W = $clog2(POOL_BITS);

   logic [IDX_W-1:0] idx;
   logic             ready_q;
   logic             sample_event;
   logic             parity;

   assign sample_event = entropy_ready & ~ready_q;
   assign parity       = ^entropy;

   // History resets high so a strobe already asserted at reset release is not an event.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ready_q      <= 1'b1;
         pool         <= '0;
         idx          <= '0;
         sample_count <= '0;
      end else begin
         ready_q <= entropy_ready;
         if (clear) begin
            pool         <= '0;
            idx          <= '0;
            sample_count <= '0;
            if (sample_event) begin
               pool[0]      <= parity;
               idx          <= IDX_W'(1);
               sample_count <= 32'd1;
            end
         end else if (sample_event) begin
            pool[idx] <= pool[idx] ^ parity;
            idx       <= idx + IDX_W'(1);
            if (sample_count != 32'hFFFF_FFFF) begin
               sample_count <= sample_count + 32'd1;
            end
         end
      end
   end

endmodule

// File: rtl/entropy_pool_scheduler.sv
// rtl/entropy_pool_scheduler.sv - fill/ready/serve FSM with round-robin key arbiter
module entropy_pool_scheduler
   import entropy_pkg::*;
#(
   parameter int POOL_BITS = POOL_BITS_DEFAULT
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [31:0]          entropy,
   input  logic                 entropy_ready,
   input  logic [31:0]          n_samples,
   input  logic [NUM_REQ-1:0]   req,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 key_valid,
   output logic [POOL_BITS-1:0] key,
   output logic                 pool_ready,
   output logic [31:0]          sample_count
);

   state_t                 state;
   logic                   last_gnt;
   logic                   winner;
   logic                   pool_full;
   logic [POOL_BITS-1:0]   pool;

   entropy_xor_pool #(.POOL_BITS(POOL_BITS)) u_pool (
      .clock        (clock),
      .reset_n      (reset_n),
      .entropy      (entropy),
      .entropy_ready(entropy_ready),
      .clear        (state == ST_SERVE),
      .pool         (pool),
      .sample_count (sample_count)
   );

   assign pool_full = (sample_count >= fill_threshold(n_samples, 32'(POOL_BITS)));

   // With both requesting, the one not served last time wins.
   always_comb begin
      winner = req[1];
      if (req == 2'b11) begin
         winner = ~last_gnt;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_FILL;
         grant      <= '0;
         key_valid  <= 1'b0;
         key        <= '0;
         pool_ready <= 1'b0;
         last_gnt   <= 1'b1;
      end else begin
         grant     <= '0;
         key_valid <= 1'b0;
         case (state)
            ST_FILL: begin
               if (pool_full) begin
                  state      <= ST_READY;
                  pool_ready <= 1'b1;
               end
            end
            ST_READY: begin
               if (req != '0) begin
                  state      <= ST_SERVE;
                  pool_ready <= 1'b0;
                  grant      <= winner ? 2'b10 : 2'b01;
                  key_valid  <= 1'b1;
                  key        <= pool;
                  last_gnt   <= winner;
               end
            end
            ST_SERVE: begin
               state <= ST_FILL;
            end
            default: begin
               state <= ST_FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_entropy_pool_scheduler.sv
// tb/tb_entropy_pool_scheduler.sv - directed self-checking bench for entropy_pool_scheduler
module tb_entropy_pool_scheduler;
   import entropy_pkg::*;

   localparam int PB = 8;

   logic          clock;
   logic          reset_n;
   logic [31:0]   entropy;
   logic          entropy_ready;
   logic [31:0]   n_samples;
   logic [1:0]    req;
   logic [1:0]    grant;
   logic          key_valid;
   logic [PB-1:0] key;
   logic          pool_ready;
   logic [31:0]   sample_count;

   int checks = 0;
   int errors = 0;
   int grant_events = 0;
   int base_events;

   logic [31:0] fill_words [8];

   entropy_pool_scheduler #(.POOL_BITS(PB)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .entropy      (entropy),
      .entropy_ready(entropy_ready),
      .n_samples    (n_samples),
      .req          (req),
      .grant        (grant),
      .key_valid    (key_valid),
      .key          (key),
      .pool_ready   (pool_ready),
      .sample_count (sample_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (grant != 2'b00) grant_events <= grant_events + 1;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic pulse(input logic [31:0] word);
      @(posedge clock); #1;
      entropy       = word;
      entropy_ready = 1'b1;
      @(posedge clock); #1;
      entropy_ready = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic do_reset();
      reset_n       = 1'b0;
      entropy_ready = 1'b0;
      req           = 2'b00;
      @(posedge clock); #1;
      reset_n = 1'b1;
   endtask

   task automatic wait_grant(input string tag, input logic [1:0] exp);
      for (int i = 0; i < 6; i++) begin
         @(posedge clock); #1;
         if (grant != 2'b00) break;
      end
      check_eq(tag, grant, exp);
      check_eq({tag, "_kv"}, key_valid, 1'b1);
   endtask

   initial begin
      fill_words[0] = 32'h0000_0001;
      fill_words[1] = 32'h0000_0003;
      fill_words[2] = 32'hFFFF_FFFE;
      fill_words[3] = 32'h0000_0007;
      fill_words[4] = 32'hFFFF_FFFF;
      fill_words[5] = 32'h0000_0000;
      fill_words[6] = 32'h8000_0000;
      fill_words[7] = 32'hF0F0_F0F0;

      reset_n       = 1'b0;
      entropy       = 32'h0;
      entropy_ready = 1'b1;
      n_samples     = 32'd3;
      req           = 2'b00;
      #12;
      check_eq("rst_grant", grant, 2'b00);
      check_eq("rst_kv", key_valid, 1'b0);
      check_eq("rst_key", key, 8'h00);
      check_eq("rst_ready", pool_ready, 1'b0);
      check_eq("rst_count", sample_count, 32'd0);
      reset_n = 1'b1;

      // Strobe held high across reset release must not register as a sample.
      repeat (5) @(posedge clock);
      #1;
      check_eq("held_ready_count", sample_count, 32'd0);
      entropy_ready = 1'b0;

      for (int i = 0; i < 7; i++) pulse(fill_words[i]);
      check_eq("t_is_poolbits", pool_ready, 1'b0);
      pulse(fill_words[7]);
      check_eq("fill_ready", pool_ready, 1'b1);
      check_eq("fill_count", sample_count, 32'd8);
      check_eq("fill_pool", dut.u_pool.pool, 8'h4D);
      check_eq("idx_wrap", dut.u_pool.idx, 3'd0);

      for (int i = 0; i < 8; i++) pulse(32'h0000_0001);
      check_eq("absorb_count", sample_count, 32'd16);
      check_eq("absorb_ready", pool_ready, 1'b1);
      req = 2'b01;
      @(posedge clock); #1;
      req = 2'b00;
      check_eq("serve_grant", grant, 2'b01);
      check_eq("serve_kv", key_valid, 1'b1);
      check_eq("serve_key", key, 8'hB2);
      @(posedge clock); #1;
      check_eq("post_grant", grant, 2'b00);
      check_eq("post_kv", key_valid, 1'b0);
      check_eq("post_count", sample_count, 32'd0);
      check_eq("post_key_hold", key, 8'hB2);
      check_eq("post_ready", pool_ready, 1'b0);

      // Both requesting across two fills: one key per fill, round-robin order.
      do_reset();
      req = 2'b11;
      base_events = grant_events;
      for (int i = 0; i < 7; i++) pulse(fill_words[i]);
      check_eq("rr_nogrant_fill1", grant_events - base_events, 0);
      pulse(fill_words[7]);
      wait_grant("rr_first", 2'b01);
      for (int i = 0; i < 7; i++) pulse(32'h0000_0003);
      check_eq("rr_one_per_fill", grant_events - base_events, 1);
      pulse(32'h0000_0003);
      wait_grant("rr_second", 2'b10);
      req = 2'b00;
      @(posedge clock); #1;
      check_eq("rr_total", grant_events - base_events, 2);

      // Sample event landing on the clear edge seeds the fresh pool.
      for (int i = 0; i < 8; i++) pulse(fill_words[i]);
      req = 2'b01;
      @(posedge clock); #1;
      check_eq("clr_serve_grant", grant, 2'b01);
      req           = 2'b00;
      entropy       = 32'h0000_0001;
      entropy_ready = 1'b1;
      @(posedge clock); #1;
      entropy_ready = 1'b0;
      check_eq("clr_pool", dut.u_pool.pool, 8'h01);
      check_eq("clr_idx", dut.u_pool.idx, 3'd1);
      check_eq("clr_count", sample_count, 32'd1);

      // Reset asserted during the serve cycle.
      for (int i = 0; i < 7; i++) pulse(32'h0000_0001);
      req = 2'b01;
      @(posedge clock); #1;
      req = 2'b00;
      check_eq("rst_serve_grant", grant, 2'b01);
      check_eq("rst_serve_key", key, 8'hFF);
      reset_n = 1'b0;
      #1;
      check_eq("midserve_grant", grant, 2'b00);
      check_eq("midserve_kv", key_valid, 1'b0);
      check_eq("midserve_key", key, 8'h00);
      check_eq("midserve_state", dut.state, ST_FILL);
      check_eq("midserve_pool", dut.u_pool.pool, 8'h00);
      #2;
      reset_n = 1'b1;

      // n_samples is read live.
      n_samples = 32'd100;
      for (int i = 0; i < 10; i++) pulse(fill_words[i % 8]);
      check_eq("live_hi_ready", pool_ready, 1'b0);
      check_eq("live_hi_count", sample_count, 32'd10);
      n_samples = 32'd5;
      @(posedge clock); #1;
      check_eq("live_lower", pool_ready, 1'b1);
      n_samples = 32'd1000;
      repeat (3) @(posedge clock);
      #1;
      check_eq("live_raise", pool_ready, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/entropy_pool_scheduler.md
ENTROPY_POOL_SCHEDULER -- requirements
Module: entropy_pool_scheduler

Interface
REQ-001 SHALL have parameter POOL_BITS, default 512, pool/key width (power of two, >= 8).
REQ-002 SHALL have port clock  input  1  sole clock; all state on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port entropy  input  32  raw audio sample word (e.g. ac97 data).
REQ-005 SHALL have port entropy_ready  input  1  sample strobe level; sampled only on its rising edge.
REQ-006 SHALL have port n_samples  input  32  minimum samples per fill (e.g. 2.7e6); read live.
REQ-007 SHALL have port req  input  2  per-requester key request, level, held until granted.
REQ-008 SHALL have port grant  output  2  one-hot one-cycle grant pulse.
REQ-009 SHALL have port key_valid  output  1  one-cycle pulse coincident with grant.
REQ-010 SHALL have port key  output  POOL_BITS  delivered key, stable from key_valid until next key_valid.
REQ-011 SHALL have port pool_ready  output  1  high while state is READY.
REQ-012 SHALL have port sample_count  output  32  samples absorbed since last clear.

Function
REQ-013 SHALL detect a sample event when entropy_ready=1 and its registered previous value=0.
REQ-014 SHALL, per event, XOR the parity of all 32 entropy bits into pool[idx] and increment idx modulo POOL_BITS (wrap POOL_BITS-1 -> 0).
REQ-015 SHALL update pool, idx and sample_count on the clock edge following the cycle the event is detected.
REQ-016 SHALL saturate sample_count at 32'hFFFF_FFFF.
REQ-017 SHALL use threshold T = max(n_samples, POOL_BITS), so every pool bit is written at least once.
REQ-018 SHALL implement states FILL, READY, SERVE.
REQ-019 FILL -> READY on the edge after sample_count >= T; READY keeps absorbing samples.
REQ-020 READY with req != 0 -> SERVE; the arbiter choice is registered at that edge.
REQ-021 Arbitration SHALL be round-robin: the requester other than the last-granted wins when both request; last-granted resets to 1 (requester 0 first).
REQ-022 SHALL, in SERVE (exactly one cycle), drive grant=chosen one-hot, key_valid=1, key=pool as of READY exit.
REQ-023 SHALL, at the SERVE -> FILL edge, clear pool, idx and sample_count to 0.
REQ-024 SHALL, if a sample event coincides with the clear edge, apply it to the cleared pool: pool[0]=parity, idx=1, sample_count=1.
REQ-025 SHALL ignore req outside READY; a req dropped before grant is not served.
REQ-026 SHALL change n_samples effect immediately: lowering it below sample_count in FILL moves to READY next edge; raising it in READY does not leave READY.
REQ-027 SHALL never issue two keys from one fill; the second requester waits for a full refill.

Reset
REQ-028 SHALL on reset_n=0 asynchronously set state=FILL, pool=0, idx=0, sample_count=0, key=0, grant=0, key_valid=0, pool_ready=0, last-granted=1.
REQ-029 SHALL reset the entropy_ready history register to 1, so a level already high at reset release is not an event.
REQ-030 SHALL, on reset mid-fill or mid-SERVE, discard the pool and assert no grant.

Structure
REQ-031 SHALL place the state enumeration, default POOL_BITS and requester count (2) in shared package entropy_pkg.
REQ-032 SHALL place edge detection plus XOR-parity pool update in sub-module entropy_xor_pool; FSM and arbiter stay in the top.

Verification (POOL_BITS=8)
REQ-033 n_samples=3, 8 events with parities 1,0,1,1,0,0,1,0 -> T=8, READY after 8th, pool=8'b0100_1101.
REQ-034 Continue 8 more events with all parity 1 in READY, then req=01 -> grant=01, key_valid one cycle, key=8'b1011_0010, sample_count=0 next cycle.
REQ-035 req=11 held across two fills -> grants 01 then 10, each a full fill apart; never two grants per fill.
REQ-036 Event coincident with clear edge, parity 1 -> pool=8'h01, idx=1, sample_count=1.
REQ-037 entropy_ready held high through reset release -> no event until it falls and rises; sample_count stays 0.
REQ-038 reset_n pulsed low during SERVE cycle -> grant/key_valid immediately 0, key=0, state FILL.
